// File: rtl/comp_serial.sv
// comp_serial: bit-serial, MSB-first magnitude comparator for two unsigned
// WIDTH-bit operands. Each CMP cycle applies a 1-bit mux comparator to the
// top bits of two shift registers; the first differing bit decides the result.
//
// Parameters:
//   WIDTH   operand width, 1..64
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset
//   start    compare request, sampled only in IDLE
//   a, b     operands, captured on the accepted start edge
//   busy     high while comparing
//   done     one-cycle pulse when the result is loaded
//   greater  a > b   (held until the next result)
//   lesser   a < b   (held until the next result)
//   equal    a == b  (held until the next result)
//
// Build option: define COMP_SERIAL_EARLY_EXIT_EN to leave CMP on the first
// differing bit; otherwise CMP always takes WIDTH cycles.
module comp_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             greater,
  output logic             lesser,
  output logic             equal
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] sa_r, sb_r, sa_nxt_s, sb_nxt_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic             gt_bit_s, lt_bit_s;
  logic             load_s, res_gt_s, res_lt_s, res_eq_s;
`ifndef COMP_SERIAL_EARLY_EXIT_EN
  // First difference is remembered here and applied when the count runs out.
  logic             decided_r, decided_nxt_s;
  logic             dec_gt_r, dec_gt_nxt_s;
`endif

  // Per-bit mux comparator on the current MSBs.
  assign gt_bit_s = sb_r[WIDTH-1] ? 1'b0 : sa_r[WIDTH-1];
  assign lt_bit_s = sa_r[WIDTH-1] ? 1'b0 : sb_r[WIDTH-1];

  // Next-state, datapath and result selection.
  always_comb begin
    state_nxt_s   = state_r;
    sa_nxt_s      = sa_r;
    sb_nxt_s      = sb_r;
    cnt_nxt_s     = cnt_r;
    load_s        = 1'b0;
    res_gt_s      = 1'b0;
    res_lt_s      = 1'b0;
    res_eq_s      = 1'b0;
`ifndef COMP_SERIAL_EARLY_EXIT_EN
    decided_nxt_s = decided_r;
    dec_gt_nxt_s  = dec_gt_r;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          sa_nxt_s      = a;
          sb_nxt_s      = b;
          cnt_nxt_s     = CW'(WIDTH - 1);
`ifndef COMP_SERIAL_EARLY_EXIT_EN
          decided_nxt_s = 1'b0;
          dec_gt_nxt_s  = 1'b0;
`endif
          state_nxt_s   = CMP;
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      CMP: begin
`ifdef COMP_SERIAL_EARLY_EXIT_EN
        if (gt_bit_s || lt_bit_s) begin
          load_s      = 1'b1;
          res_gt_s    = gt_bit_s;
          res_lt_s    = lt_bit_s;
          state_nxt_s = DONE;
        end else if (cnt_r == CW'(0)) begin
          load_s      = 1'b1;
          res_eq_s    = 1'b1;
          state_nxt_s = DONE;
        end else begin
          sa_nxt_s    = sa_r << 1;
          sb_nxt_s    = sb_r << 1;
          cnt_nxt_s   = cnt_r - CW'(1);
        end
`else
        // Latch only the first difference; later bits are ignored.
        if (!decided_r && (gt_bit_s || lt_bit_s)) begin
          decided_nxt_s = 1'b1;
          dec_gt_nxt_s  = gt_bit_s;
        end else begin
          decided_nxt_s = decided_r;
        end
        if (cnt_r == CW'(0)) begin
          load_s      = 1'b1;
          state_nxt_s = DONE;
          if (decided_r) begin
            res_gt_s = dec_gt_r;
            res_lt_s = ~dec_gt_r;
          end else if (gt_bit_s || lt_bit_s) begin
            res_gt_s = gt_bit_s;
            res_lt_s = lt_bit_s;
          end else begin
            res_eq_s = 1'b1;
          end
        end else begin
          sa_nxt_s  = sa_r << 1;
          sb_nxt_s  = sb_r << 1;
          cnt_nxt_s = cnt_r - CW'(1);
        end
`endif
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; flags change only when a result loads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      sa_r      <= '0;
      sb_r      <= '0;
      cnt_r     <= '0;
`ifndef COMP_SERIAL_EARLY_EXIT_EN
      decided_r <= 1'b0;
      dec_gt_r  <= 1'b0;
`endif
      busy      <= 1'b0;
      done      <= 1'b0;
      greater   <= 1'b0;
      lesser    <= 1'b0;
      equal     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      sa_r      <= sa_nxt_s;
      sb_r      <= sb_nxt_s;
      cnt_r     <= cnt_nxt_s;
`ifndef COMP_SERIAL_EARLY_EXIT_EN
      decided_r <= decided_nxt_s;
      dec_gt_r  <= dec_gt_nxt_s;
`endif
      busy      <= (state_nxt_s == CMP);
      done      <= (state_nxt_s == DONE);
      if (load_s) begin
        greater <= res_gt_s;
        lesser  <= res_lt_s;
        equal   <= res_eq_s;
      end
    end
  end

endmodule

// File: tb/tb_comp_serial.sv
module tb_comp_serial;

`ifdef COMP_SERIAL_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s8, s1;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;
  logic       busy8, done8, g8, l8, e8;
  logic       busy1, done1, g1, l1, e1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  comp_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .greater(g8), .lesser(l8), .equal(e8)
  );

  comp_serial #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .greater(g1), .lesser(l1), .equal(e1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] gle;
    int         lat_ee;
    int         lat_full;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One WIDTH=8 compare; operands are scrambled right after capture.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                      output int lat, output logic [2:0] gle);
    @(negedge clk); s8 = 1'b1; a8 = av; b8 = bv;
    @(negedge clk); s8 = 1'b0; a8 = ~av; b8 = av;
    chk("busy8_after_start", {63'd0, busy8}, 64'd1);
    lat = 0;
    do begin
      @(negedge clk); lat++;
    end while (!done8 && lat < 100);
    gle = {g8, l8, e8};
    chk("busy8_at_done", {63'd0, busy8}, 64'd0);
    @(negedge clk);
    chk("done8_one_cycle", {63'd0, done8}, 64'd0);
  endtask

  task automatic run1(input logic av, input logic bv,
                      output int lat, output logic [2:0] gle);
    @(negedge clk); s1 = 1'b1; a1 = av; b1 = bv;
    @(negedge clk); s1 = 1'b0; a1 = ~av; b1 = ~bv;
    lat = 0;
    do begin
      @(negedge clk); lat++;
    end while (!done1 && lat < 100);
    gle = {g1, l1, e1};
    @(negedge clk);
    chk("done1_one_cycle", {63'd0, done1}, 64'd0);
  endtask

  initial begin
    vec_t       tv[10];
    logic [2:0] gle1_exp[4];
    int         lat;
    logic [2:0] gle;
    int         dones;
    int         n;

    tv[0] = '{8'hA5, 8'hA5, 3'b001, 8, 8};
    tv[1] = '{8'h80, 8'h7F, 3'b100, 1, 8};
    tv[2] = '{8'h12, 8'h13, 3'b010, 8, 8};
    tv[3] = '{8'h00, 8'hFF, 3'b010, 1, 8};
    tv[4] = '{8'hFF, 8'hFE, 3'b100, 8, 8};
    tv[5] = '{8'h3C, 8'h34, 3'b100, 5, 8};
    tv[6] = '{8'h00, 8'h00, 3'b001, 8, 8};
    tv[7] = '{8'h7F, 8'h80, 3'b010, 1, 8};
    tv[8] = '{8'hFF, 8'hFF, 3'b001, 8, 8};
    tv[9] = '{8'h12, 8'h13, 3'b010, 8, 8};
    gle1_exp[0] = 3'b001;
    gle1_exp[1] = 3'b010;
    gle1_exp[2] = 3'b100;
    gle1_exp[3] = 3'b001;

    rst_n = 1'b0; s8 = 1'b0; s1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; a1 = 1'b0; b1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy8", {63'd0, busy8}, 64'd0);
    chk("reset_done8", {63'd0, done8}, 64'd0);
    chk("reset_flags8", {61'd0, g8, l8, e8}, 64'd0);
    chk("reset_flags1", {61'd0, g1, l1, e1}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run8(tv[i].a, tv[i].b, lat, gle);
      chk($sformatf("vec%0d_flags", i), {61'd0, gle}, {61'd0, tv[i].gle});
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(EE ? tv[i].lat_ee : tv[i].lat_full));
    end

    // Last vector was 12 vs 13: flags must hold through idle cycles.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold_flags_%0d", k), {61'd0, g8, l8, e8}, 64'b010);
    end

    for (int i = 0; i < 4; i++) begin
      run1(i[1], i[0], lat, gle);
      chk($sformatf("w1_pair%0d_flags", i), {61'd0, gle}, {61'd0, gle1_exp[i]});
      chk($sformatf("w1_pair%0d_latency", i), 64'(lat), 64'd1);
    end

    // start held high; operands wander while busy.
    dones = 0;
    @(negedge clk); s8 = 1'b1; a8 = 8'hA1; b8 = 8'hA0;
    @(negedge clk); a8 = 8'h00; b8 = 8'hFF;
    n = 0;
    while (!done8 && n < 100) begin
      @(negedge clk); n++;
    end
    if (done8) dones++;
    chk("held_first_flags", {61'd0, g8, l8, e8}, 64'b100);
    a8 = 8'h05; b8 = 8'h09;
    repeat (2) begin
      @(negedge clk);
      if (done8) dones++;
    end
    a8 = 8'h30; b8 = 8'h10; s8 = 1'b0;
    gle = 3'b000;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done8) begin
        dones++;
        gle = {g8, l8, e8};
      end
    end
    chk("held_second_flags", {61'd0, gle}, 64'b010);
    chk("held_done_count", 64'(dones), 64'd2);

    // Reset during the third CMP cycle aborts the compare.
    @(negedge clk); s8 = 1'b1; a8 = 8'hA5; b8 = 8'hA5;
    @(negedge clk); s8 = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("abort_busy", {63'd0, busy8}, 64'd0);
    chk("abort_done", {63'd0, done8}, 64'd0);
    chk("abort_flags", {61'd0, g8, l8, e8}, 64'd0);
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    run8(8'h01, 8'h00, lat, gle);
    chk("after_abort_flags", {61'd0, gle}, 64'b100);
    chk("after_abort_latency", 64'(lat), 64'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
